// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: INIT sequencer and two-port arbiter for the shared single-port memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with a port-1 starvation guard.
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module mem_port_arbiter #(
   parameter int AW          = `ISIZE,
   parameter int DW          = `DSIZE,
   parameter int INIT_CYCLES = 4,
   parameter int MAX_WAIT    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          wen0,
   input  logic          wen1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          mem_rst,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int WW = $clog2(MAX_WAIT + 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic          run, win1;
`ifdef MEM_ARB_RR_EN
   logic          ptr_q, ptr_d;
`else
   logic [WW-1:0] wait_q, wait_d;
`endif

   always_comb begin
      run = state_q == RUN;
      busy = !run;
      mem_rst = !run;
`ifdef MEM_ARB_RR_EN
      win1 = req1 && (!req0 || ptr_q);
      ptr_d = ptr_q;
`else
      win1 = req1 && (!req0 || wait_q == WW'(MAX_WAIT));
`endif
      gnt1 = run && win1;
      gnt0 = run && req0 && !win1;
      mem_wen = gnt0 ? wen0 : gnt1 ? wen1 : 1'b0;
      // with no grant the address bus parks on the last granted address
      mem_addr = gnt0 ? addr0 : gnt1 ? addr1 : addr_q;
      mem_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
      addr_d = mem_addr;
      rvalid0_d = gnt0 && !wen0;
      rvalid1_d = gnt1 && !wen1;
      state_d = (run || cnt_q == '0) ? RUN : INIT;
      cnt_d = (run || cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
`ifdef MEM_ARB_RR_EN
      ptr_d = gnt0 ? 1'b1 : gnt1 ? 1'b0 : ptr_q;
`else
      wait_d = (run && req1 && !gnt1) ? wait_q + 1'b1 : '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= INIT;
         cnt_q     <= CW'(INIT_CYCLES - 1);
         addr_q    <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
         ptr_q     <= 1'b0;
`else
         wait_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
`ifdef MEM_ARB_RR_EN
         ptr_q     <= ptr_d;
`else
         wait_q    <= wait_d;
`endif
      end
   end

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata   = mem_rdata;

endmodule
